// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared FSM encodings and constants for the GPR file
package regfile_mp_pkg;

  typedef enum logic {
    RF_ST_CLEAR = 1'b0,
    RF_ST_READY = 1'b1
  } rf_state_e;

  localparam int RF_ZERO_IDX = 0;

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write port bundle between pipeline (master) and GPR file (slave)
interface regfile_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
);

  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data;
  logic                           wr0_en;
  logic [ADDR_WIDTH-1:0]          wr0_addr;
  logic [DATA_WIDTH-1:0]          wr0_data;
  logic                           wr1_en;
  logic [ADDR_WIDTH-1:0]          wr1_addr;
  logic [DATA_WIDTH-1:0]          wr1_data;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    input  rd_data
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    output rd_data
  );

endinterface

// File: rtl/regfile_mp_clear_walker.sv
// rtl/regfile_mp_clear_walker.sv - post-reset clear walker: zeroes one entry per cycle, then raises ready
module rf_clear_walker
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clearReq,
  output logic                  ready,
  output logic [ADDR_WIDTH-1:0] clrIdx,
  output logic                  clrWe
);

  rf_state_e             state;
  rf_state_e             stateNext;
  logic [ADDR_WIDTH-1:0] idxNext;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= RF_ST_CLEAR;
      clrIdx <= '0;
    end else begin
      state  <= stateNext;
      clrIdx <= idxNext;
    end
  end

  always_comb begin
    stateNext = state;
    idxNext   = clrIdx;
    clrWe     = 1'b0;
    ready     = 1'b0;
    unique case (state)
      RF_ST_CLEAR: begin
        // Index wraps back to 0 as the last entry is written.
        clrWe   = 1'b1;
        idxNext = clrIdx + ADDR_WIDTH'(1);
        if (clrIdx == '1) begin
          stateNext = RF_ST_READY;
        end
      end
      RF_ST_READY: begin
        ready = 1'b1;
        if (clearReq) begin
          stateNext = RF_ST_CLEAR;
          idxNext   = '0;
        end
      end
      default: stateNext = RF_ST_CLEAR;
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port GPR file: N read ports, two write ports, optional bypass and zero entry
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_req,
  output logic                  ready,
  output logic [ADDR_WIDTH-1:0] clr_idx,
  regfile_mp_if.slave           bus
);

  localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(RF_ZERO_IDX);

  logic                  clrWe;
  logic                  wr0Ok;
  logic                  wr1Ok;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  rf_clear_walker #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) uWalker (
    .clock   (clock),
    .reset   (reset),
    .clearReq(clear_req),
    .ready   (ready),
    .clrIdx  (clr_idx),
    .clrWe   (clrWe)
  );

  assign wr0Ok = bus.wr0_en && ready && !reset &&
                 !((ZERO_REG != 0) && (bus.wr0_addr == ZERO_IDX));
  assign wr1Ok = bus.wr1_en && ready && !reset &&
                 !((ZERO_REG != 0) && (bus.wr1_addr == ZERO_IDX));

  // No reset on the array itself; the walker is what zeroes it. Port 1 is written last so it wins.
  always_ff @(posedge clock) begin
    if (clrWe) begin
      mem[clr_idx] <= '0;
    end else begin
      if (wr0Ok) begin
        mem[bus.wr0_addr] <= bus.wr0_data;
      end
      if (wr1Ok) begin
        mem[bus.wr1_addr] <= bus.wr1_data;
      end
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] word;

    assign addr = bus.rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      word = mem[addr];
      if (!ready) begin
        word = '0;
      end else if ((ZERO_REG != 0) && (addr == ZERO_IDX)) begin
        word = '0;
      end else if ((BYPASS != 0) && bus.wr1_en && (bus.wr1_addr == addr)) begin
        word = bus.wr1_data;
      end else if ((BYPASS != 0) && bus.wr0_en && (bus.wr0_addr == addr)) begin
        word = bus.wr0_data;
      end
    end

    assign bus.rd_data[k*DATA_WIDTH +: DATA_WIDTH] = word;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench: dutA (4 reads, zero reg, bypass) and dutB (2 reads, plain, no bypass)
module tb_regfile_mp;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear_req = 1'b0;
  logic       readyA, readyB;
  logic [4:0] clrIdxA, clrIdxB;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    int          cyc;
    int          dut;
    int          kind;
    int          port;
    int          tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];

  regfile_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(4)) ifA ();
  regfile_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) ifB ();

  regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(4), .ZERO_REG(1), .BYPASS(1)) dutA (
    .clock(clock), .reset(reset), .clear_req(clear_req), .ready(readyA), .clr_idx(clrIdxA), .bus(ifA)
  );

  regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(0), .BYPASS(0)) dutB (
    .clock(clock), .reset(reset), .clear_req(clear_req), .ready(readyB), .clr_idx(clrIdxB), .bus(ifB)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: everything queued for the current cycle is compared mid-cycle.
  always @(negedge clock) begin : monitor
    sb_t         e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        0:       act = (e.dut == 0) ? ifA.rd_data[e.port*32 +: 32] : ifB.rd_data[e.port*32 +: 32];
        1:       act = {31'b0, (e.dut == 0) ? readyA : readyB};
        default: act = {27'b0, (e.dut == 0) ? clrIdxA : clrIdxB};
      endcase
      checks++;
      if (e.cyc != cyc || act !== e.exp) begin
        errors++;
        $display("FAIL t%0d dut%0d %s port%0d cyc%0d: got %h expected %h", e.tag, e.dut,
                 (e.kind == 0) ? "rd_data" : (e.kind == 1) ? "ready" : "clr_idx", e.port, cyc, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int dut, input int kind, input int port, input int tag, input logic [31:0] exp);
    sb_t e;
    e.cyc = cyc; e.dut = dut; e.kind = kind; e.port = port; e.tag = tag; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic expRd(input int dut, input int port, input int tag, input logic [31:0] exp);
    push(dut, 0, port, tag, exp);
  endtask

  task automatic expRdy(input int tag, input logic v);
    push(0, 1, 0, tag, {31'b0, v});
    push(1, 1, 0, tag, {31'b0, v});
  endtask

  task automatic expIdx(input int tag, input int v);
    push(0, 2, 0, tag, 32'(v));
  endtask

  task automatic setRd(input int a0, input int a1, input int a2, input int a3);
    ifA.rd_addr = {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    ifB.rd_addr = {5'(a1), 5'(a0)};
  endtask

  task automatic setWr(input logic e0, input int a0, input logic [31:0] d0,
                       input logic e1, input int a1, input logic [31:0] d1);
    ifA.wr0_en = e0; ifA.wr0_addr = 5'(a0); ifA.wr0_data = d0;
    ifA.wr1_en = e1; ifA.wr1_addr = 5'(a1); ifA.wr1_data = d1;
    ifB.wr0_en = e0; ifB.wr0_addr = 5'(a0); ifB.wr0_data = d0;
    ifB.wr1_en = e1; ifB.wr1_addr = 5'(a1); ifB.wr1_data = d1;
  endtask

  // Read all 32 entries through every port and expect zero on both DUTs.
  task automatic sweepZero(input int tag);
    for (int a = 0; a < 8; a++) begin
      setRd(4*a, 4*a+1, 4*a+2, 4*a+3);
      for (int p = 0; p < 4; p++) expRd(0, p, tag, 32'h0);
      expRd(1, 0, tag, 32'h0);
      expRd(1, 1, tag, 32'h0);
      step();
    end
  endtask

  initial begin
    setRd(0, 0, 0, 0);
    setWr(1'b0, 0, 32'h0, 1'b0, 0, 32'h0);

    // 1: one reset cycle, then 32 walk cycles with ready low and reads forced to zero
    step();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      setRd(i, 31 - i, 0, 31);
      expRdy(1, 1'b0);
      expIdx(1, i);
      expRd(0, 0, 1, 32'h0);
      expRd(1, 1, 1, 32'h0);
      step();
    end
    expRdy(1, 1'b1);
    expIdx(1, 0);
    sweepZero(1);

    // 2: plain write, read back next cycle
    setWr(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 32'h0);
    setRd(5, 0, 5, 0);
    expRd(0, 0, 2, 32'hDEADBEEF);
    expRd(1, 0, 2, 32'h0);
    step();
    setWr(1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
    expRd(0, 0, 2, 32'hDEADBEEF); expRd(0, 1, 2, 32'h0);
    expRd(1, 0, 2, 32'hDEADBEEF); expRd(1, 1, 2, 32'h0);
    step();

    // 3: both ports to the same address, port 1 wins; bypass vs old data
    setWr(1'b1, 7, 32'h11111111, 1'b1, 7, 32'h22222222);
    setRd(7, 5, 7, 7);
    expRd(0, 0, 3, 32'h22222222); expRd(0, 1, 3, 32'hDEADBEEF);
    expRd(1, 0, 3, 32'h0);        expRd(1, 1, 3, 32'hDEADBEEF);
    step();
    setWr(1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
    expRd(0, 0, 3, 32'h22222222);
    expRd(1, 0, 3, 32'h22222222);
    step();

    // 4: write to entry 0 (discarded on A, stored on B)
    setWr(1'b0, 0, 32'h0, 1'b1, 0, 32'hFFFFFFFF);
    setRd(0, 0, 0, 0);
    expRd(0, 0, 4, 32'h0);
    expRd(1, 0, 4, 32'h0);
    step();
    setWr(1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
    expRd(0, 0, 4, 32'h0); expRd(0, 3, 4, 32'h0);
    expRd(1, 0, 4, 32'hFFFFFFFF);
    step();

    // 5: fill r1..r31, clear_req walk with dropped writes and an ignored second clear_req
    for (int i = 1; i < 32; i++) begin
      setWr(1'b1, i, 32'h10000000 + 32'(i), 1'b0, 0, 32'h0);
      step();
    end
    setWr(1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
    setRd(3, 31, 0, 1);
    expRd(0, 0, 5, 32'h10000003); expRd(0, 1, 5, 32'h1000001F);
    expRd(0, 2, 5, 32'h0);        expRd(0, 3, 5, 32'h10000001);
    expRd(1, 0, 5, 32'h10000003); expRd(1, 1, 5, 32'h1000001F);
    clear_req = 1'b1;
    expRdy(5, 1'b1);
    step();
    clear_req = 1'b0;
    for (int i = 0; i < 32; i++) begin
      clear_req = (i == 5);
      setWr(1'b1, (i > 0) ? i - 1 : 0, 32'h0BAD0000, 1'b1, i / 2, 32'h0BAD1111);
      setRd(3, 31, 1, i);
      expRdy(5, 1'b0);
      expIdx(5, i);
      expRd(0, 0, 5, 32'h0);
      expRd(1, 1, 5, 32'h0);
      step();
    end
    clear_req = 1'b0;
    setWr(1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
    expRdy(5, 1'b1);
    sweepZero(5);

    // 6: reset at clr_idx=10 restarts the walk; bypass on all four ports afterwards
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    expIdx(6, 10);
    expRdy(6, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      expRdy(6, 1'b0);
      expIdx(6, i);
      step();
    end
    expRdy(6, 1'b1);
    setWr(1'b1, 9, 32'hAAAAAAAA, 1'b1, 9, 32'h12345678);
    setRd(9, 9, 9, 9);
    for (int p = 0; p < 4; p++) expRd(0, p, 6, 32'h12345678);
    expRd(1, 0, 6, 32'h0); expRd(1, 1, 6, 32'h0);
    step();
    setWr(1'b1, 10, 32'h00000055, 1'b0, 0, 32'h0);
    setRd(9, 0, 10, 9);
    expRd(0, 0, 6, 32'h12345678); expRd(0, 1, 6, 32'h0);
    expRd(0, 2, 6, 32'h00000055); expRd(0, 3, 6, 32'h12345678);
    expRd(1, 0, 6, 32'h12345678); expRd(1, 1, 6, 32'h0);
    step();
    setWr(1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
    step();
    step();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
